// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: round-robin arbiter of I-cache and D-cache line traffic onto one memory port
//   clk, reset         : clock, asynchronous active-high reset
//   i_read/i_address   : I-cache line read request, held until i_resp
//   i_resp/i_rdata     : one-cycle completion pulse and returned line (held until next i_resp)
//   d_read/d_write     : D-cache line read / write-back request, held until d_resp
//   d_address/d_wdata  : D-cache line address and write-back data
//   d_resp/d_rdata     : one-cycle completion pulse and returned line (held until next d_resp)
//   pmem_read/write    : memory strobes, held steady for the whole access
//   pmem_address/wdata : latched address and write data
//   pmem_resp/rdata    : memory completion pulse and read data
module line_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [LINE_WIDTH-1:0] pmem_rdata
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;
  state_t state, state_n;
  logic i_pend, d_pend, grant_d, last_d, is_write;
  assign i_pend = i_read;
  assign d_pend = d_read | d_write;
  // D wins when alone, or on a tie when I was granted last (last_d resets to I)
  assign grant_d = d_pend & (~i_pend | ~last_d);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // Strobes and resp are decoded from state so an async reset drops them at once
  always_comb begin
    state_n = state;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    i_resp = 1'b0;
    d_resp = 1'b0;
    unique case (state)
      IDLE: state_n = (i_pend | d_pend) ? (grant_d ? SERVE_D : SERVE_I) : IDLE;
      SERVE_I: begin
        pmem_read = 1'b1;
        state_n = pmem_resp ? RELEASE : SERVE_I;
      end
      SERVE_D: begin
        pmem_read = ~is_write;
        pmem_write = is_write;
        state_n = pmem_resp ? RELEASE : SERVE_D;
      end
      RELEASE: begin
        i_resp = ~last_d;
        d_resp = last_d;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // Per-client line registers double as the returned-line hold registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      last_d <= 1'b0;
      is_write <= 1'b0;
      pmem_address <= '0;
      pmem_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if (state == IDLE && (i_pend | d_pend)) begin
        pmem_address <= grant_d ? d_address : i_address;
        last_d <= grant_d;
        if (grant_d) begin
          pmem_wdata <= d_wdata;
          is_write <= d_write;
        end
      end
      if (state == SERVE_I && pmem_resp) i_rdata <= pmem_rdata;
      if (state == SERVE_D && pmem_resp) d_rdata <= pmem_rdata;
    end
endmodule

// File: tb/tb_line_mem_arbiter.sv
// tb_line_mem_arbiter: directed self-checking bench for line_mem_arbiter
module tb_line_mem_arbiter;
  logic clk = 0, reset = 0;
  logic i_read = 0, d_read = 0, d_write = 0, pmem_resp = 0;
  logic [15:0] i_address = '0, d_address = '0, pmem_address;
  logic [255:0] d_wdata = '0, pmem_rdata = '0, i_rdata, d_rdata, pmem_wdata;
  logic i_resp, d_resp, pmem_read, pmem_write;
  logic [255:0] mem [logic [15:0]];
  int vectors = 0, miscompares = 0;
  localparam logic [255:0] LA5 = {32{8'hA5}};
  localparam logic [255:0] LDB = {8{32'hDEADBEEF}};
  localparam logic [255:0] L3C = {16{16'h3C3C}};
  localparam logic [255:0] L77 = {32{8'h77}};
  localparam logic [255:0] L12 = {8{32'h12345678}};
  localparam logic [255:0] L9E = {32{8'h9E}};

  line_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: waits lat cycles watching the strobe and address, then
  // completes the access; writes are stored, reads return stored line or fill.
  task automatic respond(input string tag, input int lat, input logic [255:0] fill);
    logic ok;
    logic [15:0] a;
    ok = 1'b1;
    a = pmem_address;
    for (int k = 0; k < lat; k++) begin
      if (!(pmem_read | pmem_write) || pmem_address !== a) ok = 1'b0;
      tick();
    end
    if (!(pmem_read | pmem_write) || pmem_address !== a) ok = 1'b0;
    chk({tag, "_strobe_held"}, 256'(ok), 256'(1));
    if (pmem_write) mem[a] = pmem_wdata;
    pmem_rdata = mem.exists(a) ? mem[a] : fill;
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    pmem_rdata = '1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    tick();
    chk("rst_pmem_read", 256'(pmem_read), 256'(0));
    chk("rst_pmem_write", 256'(pmem_write), 256'(0));
    chk("rst_pmem_address", 256'(pmem_address), 256'(0));
    chk("rst_pmem_wdata", pmem_wdata, '0);
    chk("rst_resps", 256'({i_resp, d_resp}), 256'(0));
    chk("rst_rdata", i_rdata | d_rdata, '0);
    reset = 1'b0;
    tick();

    // stray memory response while idle must be ignored
    pmem_resp = 1'b1;
    pmem_rdata = L9E;
    tick();
    pmem_resp = 1'b0;
    chk("stray_resp_state", 256'({i_resp, d_resp, pmem_read, pmem_write}), 256'(0));
    tick();
    chk("stray_resp_rdata", i_rdata | d_rdata, '0);

    // single I read
    i_read = 1'b1;
    i_address = 16'h0040;
    tick();
    chk("i_strobe", 256'({pmem_read, pmem_write}), 256'(2'b10));
    chk("i_addr", 256'(pmem_address), 256'(16'h0040));
    respond("i_read", 25, LA5);
    chk("i_resp", 256'({i_resp, d_resp}), 256'(2'b10));
    chk("i_rdata", i_rdata, LA5);
    chk("i_release_strobe", 256'(pmem_read), 256'(0));
    i_read = 1'b0;
    tick();
    chk("i_resp_once", 256'(i_resp), 256'(0));
    chk("i_rdata_hold", i_rdata, LA5);

    // D write-back, then read the line back through I
    d_write = 1'b1;
    d_address = 16'h1FE0;
    d_wdata = LDB;
    tick();
    chk("dw_strobe", 256'({pmem_read, pmem_write}), 256'(2'b01));
    chk("dw_addr", 256'(pmem_address), 256'(16'h1FE0));
    chk("dw_wdata", pmem_wdata, LDB);
    d_wdata = '0;
    respond("d_write", 8, '0);
    chk("dw_resp", 256'({i_resp, d_resp}), 256'(2'b01));
    d_write = 1'b0;
    tick();
    chk("dw_resp_once", 256'(d_resp), 256'(0));
    i_read = 1'b1;
    i_address = 16'h1FE0;
    tick();
    respond("i_readback", 3, LA5);
    chk("readback_rdata", i_rdata, LDB);
    i_read = 1'b0;
    tick();

    // read+write together is a write
    d_read = 1'b1;
    d_write = 1'b1;
    d_address = 16'h0A00;
    d_wdata = L12;
    tick();
    chk("rw_is_write", 256'({pmem_read, pmem_write}), 256'(2'b01));
    respond("d_rw", 2, '0);
    d_read = 1'b0;
    d_write = 1'b0;
    tick();

    // tie after reset: D first, then I
    do_reset();
    i_read = 1'b1;
    i_address = 16'h0300;
    d_read = 1'b1;
    d_address = 16'h0400;
    tick();
    chk("tie1_first_d", 256'({pmem_read, pmem_address}), 256'({1'b1, 16'h0400}));
    respond("tie1_d", 4, L3C);
    chk("tie1_d_resp", 256'({i_resp, d_resp}), 256'(2'b01));
    chk("tie1_d_rdata", d_rdata, L3C);
    d_read = 1'b0;
    tick();
    tick();
    chk("tie1_then_i", 256'({pmem_read, pmem_address}), 256'({1'b1, 16'h0300}));
    respond("tie1_i", 4, L77);
    chk("tie1_i_resp", 256'({i_resp, d_resp}), 256'(2'b10));
    chk("tie1_d_rdata_hold", d_rdata, L3C);
    i_read = 1'b0;
    tick();

    // D alone, then tie: I wins because D was granted last
    d_read = 1'b1;
    d_address = 16'h0500;
    tick();
    respond("solo_d", 2, L12);
    d_read = 1'b0;
    tick();
    i_read = 1'b1;
    d_read = 1'b1;
    tick();
    chk("tie2_first_i", 256'({pmem_read, pmem_address}), 256'({1'b1, 16'h0300}));
    respond("tie2_i", 3, L77);
    chk("tie2_i_resp", 256'({i_resp, d_resp}), 256'(2'b10));
    i_read = 1'b0;
    tick();
    tick();
    chk("tie2_then_d", 256'(pmem_address), 256'(16'h0500));
    respond("tie2_d", 3, L12);
    chk("tie2_d_resp", 256'({i_resp, d_resp}), 256'(2'b01));
    d_read = 1'b0;
    tick();

    // address change mid-serve must not reach memory
    d_read = 1'b1;
    d_address = 16'h0100;
    tick();
    d_address = 16'h0200;
    i_read = 1'b1;
    tick();
    chk("stable_addr", 256'(pmem_address), 256'(16'h0100));
    respond("stable", 6, L3C);
    chk("stable_resp", 256'({i_resp, d_resp}), 256'(2'b01));
    i_read = 1'b0;
    d_read = 1'b0;
    tick();

    // back-to-back D reads: strobe low in RELEASE and IDLE, rises at N+2
    d_read = 1'b1;
    d_address = 16'h0600;
    tick();
    respond("b2b_1", 2, L77);
    chk("b2b_release", 256'({pmem_read, d_resp}), 256'(2'b01));
    tick();
    chk("b2b_idle", 256'({pmem_read, d_resp}), 256'(2'b00));
    tick();
    chk("b2b_restrobe", 256'(pmem_read), 256'(1));
    respond("b2b_2", 2, L9E);
    chk("b2b_2_rdata", d_rdata, L9E);
    d_read = 1'b0;
    tick();

    // async reset mid-SERVE_I
    i_read = 1'b1;
    i_address = 16'h0700;
    tick();
    tick();
    #3 reset = 1'b1;
    #1;
    chk("async_rst_strobe", 256'({pmem_read, i_resp}), 256'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    chk("async_rst_idle", 256'({pmem_read, i_resp}), 256'(0));
    tick();
    chk("post_rst_grant", 256'({pmem_read, pmem_address}), 256'({1'b1, 16'h0700}));
    respond("post_rst", 5, LA5);
    chk("post_rst_resp", 256'({i_resp, i_rdata}), {1'b1, LA5[254:0]} | 256'(0) ? 256'({1'b1, LA5}) : 256'(0));
    i_read = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
